// File: rtl/spi_leader_xfer_if.sv
// Purpose: CPU-side control/status and SPI pin bundle for spi_leader_xfer.
// Latency: none (wires only).
// Backpressure: none; start is ignored by the engine while busy is high.
// master: engine view (takes start/config/tx_data/miso, drives busy/done/rx_data/sclk/mosi/cs_n).
// slave : environment view (register file plus follower pins).
interface spi_leader_xfer_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
);
    localparam int LW  = $clog2(DATA_W + 1);
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  div;
    logic [LW-1:0]     len;
    logic [CSW-1:0]    cs_sel;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic              mosi;
    logic [NUM_CS-1:0] cs_n;

    modport master (
        input  start, cpol, cpha, div, len, cs_sel, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, cs_n
    );

    modport slave (
        output start, cpol, cpha, div, len, cs_sel, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_leader_xfer.sv
// Purpose: SPI leader transfer engine, 1..DATA_W bits, CPOL/CPHA modes, div+1 half-period, NUM_CS selects.
// Latency: start to done = (2L+1)*(div+1)+1 clk cycles; full duplex, MSB first.
// Backpressure: start is accepted only while busy=0 (the done cycle included); starts while busy are dropped.
// Ports: clk, rst (sync, active-high); bus (master modport): start/cpol/cpha/div/len/cs_sel/tx_data in,
//        busy/done/rx_data out, sclk/mosi/cs_n to the follower, miso from it.
module spi_leader_xfer #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    spi_leader_xfer_if.master   bus
);
    localparam int LW  = $clog2(DATA_W + 1);
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    // Edge counter must reach 2*DATA_W, which always fits in LW+1 bits.
    localparam int EW  = LW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [DIV_W:0]    cnt, cnt_nxt;
    logic [EW-1:0]     edge_cnt, edge_nxt;
    logic [LW-1:0]     len_l, len_nxt;
    logic [DIV_W-1:0]  div_l, div_nxt;
    logic              cpol_l, cpol_nxt;
    logic              cpha_l, cpha_nxt;
    logic [NUM_CS-1:0] cs_q, cs_nxt;
    logic [DATA_W-1:0] tx_sh, tx_nxt;
    logic [DATA_W-1:0] rx_sh, rx_nxt;
    logic [DATA_W-1:0] rxd_q, rxd_nxt;
    logic              sclk_q, sclk_nxt;
    logic              mosi_q, mosi_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;

    logic [LW-1:0]     l_in;
    logic [DATA_W-1:0] tx_al;
    logic [NUM_CS-1:0] cs_dec;
    logic              half_end;
    logic [EW-1:0]     k_nxt;
    logic [EW-1:0]     two_l;
    logic              do_drive;
    logic              do_sample;

    // Effective length: 0 or anything above DATA_W means a full-width transfer.
    always_comb begin
        l_in = bus.len;
        if (bus.len == '0 || bus.len > LW'(DATA_W)) begin
            l_in = LW'(DATA_W);
        end
    end

    // Left-justify the word so the first bit out is always the shift register MSB.
    assign tx_al = bus.tx_data << (LW'(DATA_W) - l_in);

    // Out-of-range select matches no output, so every cs_n stays high.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (bus.cs_sel == CSW'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    assign half_end = (cnt == {1'b0, div_l});
    assign k_nxt    = edge_cnt + EW'(1);
    assign two_l    = {len_l, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            len_l    <= '0;
            div_l    <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            cs_q     <= '1;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rxd_q    <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            edge_cnt <= edge_nxt;
            len_l    <= len_nxt;
            div_l    <= div_nxt;
            cpol_l   <= cpol_nxt;
            cpha_l   <= cpha_nxt;
            cs_q     <= cs_nxt;
            tx_sh    <= tx_nxt;
            rx_sh    <= rx_nxt;
            rxd_q    <= rxd_nxt;
            sclk_q   <= sclk_nxt;
            mosi_q   <= mosi_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        edge_nxt  = edge_cnt;
        len_nxt   = len_l;
        div_nxt   = div_l;
        cpol_nxt  = cpol_l;
        cpha_nxt  = cpha_l;
        cs_nxt    = cs_q;
        tx_nxt    = tx_sh;
        rx_nxt    = rx_sh;
        rxd_nxt   = rxd_q;
        sclk_nxt  = sclk_q;
        mosi_nxt  = mosi_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        do_drive  = 1'b0;
        do_sample = 1'b0;

        unique case (state)
            IDLE: begin
                sclk_nxt = bus.cpol;
                if (bus.start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    edge_nxt  = '0;
                    len_nxt   = l_in;
                    div_nxt   = bus.div;
                    cpol_nxt  = bus.cpol;
                    cpha_nxt  = bus.cpha;
                    cs_nxt    = cs_dec;
                    busy_nxt  = 1'b1;
                    rx_nxt    = '0;
                    // cpha=0 presents the first bit before the first edge;
                    // cpha=1 leaves mosi alone until the leading edge.
                    if (!bus.cpha) begin
                        mosi_nxt = tx_al[DATA_W-1];
                        tx_nxt   = {tx_al[DATA_W-2:0], 1'b0};
                    end else begin
                        tx_nxt   = tx_al;
                    end
                end
            end
            SHIFT: begin
                if (half_end) begin
                    cnt_nxt  = '0;
                    edge_nxt = k_nxt;
                    sclk_nxt = ~sclk_q;
                    if (k_nxt[0]) begin
                        // leading edge
                        do_drive  = cpha_l;
                        do_sample = ~cpha_l;
                    end else begin
                        // trailing edge; the last one has no further bit to drive
                        do_sample = cpha_l;
                        do_drive  = ~cpha_l && (k_nxt != two_l);
                    end
                    if (k_nxt == two_l) begin
                        state_nxt = HOLD;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (half_end) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    cs_nxt    = '1;
                    rxd_nxt   = rx_sh;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (do_drive) begin
            mosi_nxt = tx_sh[DATA_W-1];
            tx_nxt   = {tx_sh[DATA_W-2:0], 1'b0};
        end
        // Shifting in from the bottom leaves the L bits right-aligned with zeros above.
        if (do_sample) begin
            rx_nxt = {rx_sh[DATA_W-2:0], bus.miso};
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rxd_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_q;
endmodule

// File: tb/tb_spi_leader_xfer.sv
// Purpose: scoreboard bench for spi_leader_xfer; directed transfers with hand-computed results.
// Latency: n/a.
// Backpressure: n/a. NUM_CS=5 so that cs_sel=7 is representable and out of range.
module tb_spi_leader_xfer;
    localparam int DATA_W = 16;
    localparam int NUM_CS = 5;
    localparam int DIV_W  = 8;

    typedef struct {
        logic [15:0] rx;
        int          lat;
        logic [4:0]  cs;
        int          tog;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_leader_xfer_if #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) bus ();

    spi_leader_xfer #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Follower: loopback, or a mode-3 responder shifting out on each leading edge.
    logic        fol_en   = 1'b0;
    logic        fol_miso = 1'b0;
    logic        fol_prev = 1'b0;
    logic [15:0] fol_sh   = '0;
    assign bus.miso = fol_en ? fol_miso : bus.mosi;

    always @(negedge clk) begin
        if (fol_en && bus.sclk !== fol_prev && bus.sclk !== bus.cpol) begin
            fol_miso = fol_sh[15];
            fol_sh   = {fol_sh[14:0], 1'b0};
        end
        fol_prev = bus.sclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Monitor
    int   cyc = 0;
    int   rise_cyc = 0;
    int   last_done_cyc = 0;
    int   gap = 0;
    int   tog = 0;
    int   done_seen = 0;
    logic cs_bad = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_sclk = 1'b0;
    logic done_chk_next = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done_chk_next) begin
            chk("done_single_cycle", bus.done, 0);
            done_chk_next = 1'b0;
        end
        if (bus.busy && !prev_busy) begin
            rise_cyc = cyc;
            tog      = 0;
            cs_bad   = 1'b0;
            gap      = cyc - last_done_cyc;
        end
        if (bus.busy) begin
            if (bus.sclk !== prev_sclk) tog++;
            if (exp_q.size() > 0 && bus.cs_n !== exp_q[0].cs) cs_bad = 1'b1;
        end
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulse at cycle %0d, none expected", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", bus.rx_data, e.rx);
                chk("latency", cyc - rise_cyc + 1, e.lat);
                chk("sclk_toggles", tog, e.tog);
                chk("cs_n_busy_mismatch", cs_bad, 0);
                chk("cs_n_at_done", bus.cs_n, 5'b11111);
                chk("busy_at_done", bus.busy, 0);
                if (e.gap >= 0) chk("cs_gap", gap, e.gap);
            end
            done_seen++;
            last_done_cyc = cyc;
            done_chk_next = 1'b1;
        end
        prev_busy = bus.busy;
        prev_sclk = bus.sclk;
    end

    task automatic setup(input logic p, input logic a, input logic [7:0] d, input logic [4:0] l,
                         input logic [2:0] cs, input logic [15:0] tx);
        bus.cpol    = p;
        bus.cpha    = a;
        bus.div     = d;
        bus.len     = l;
        bus.cs_sel  = cs;
        bus.tx_data = tx;
        repeat (2) @(negedge clk);
        chk("sclk_idle", bus.sclk, p);
    endtask

    // Issues one start pulse; returns at the negedge of cycle 1.
    task automatic fire(input exp_t e, input logic push);
        if (push) exp_q.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int i = 0;
        while (done_seen < n && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (done_seen < n) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: saw %0d done pulses, expected %0d", done_seen, n);
        end
        @(negedge clk);
    endtask

    initial begin
        int base;
        bus.start   = 1'b0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.div     = '0;
        bus.len     = '0;
        bus.cs_sel  = '0;
        bus.tx_data = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_cs_n", bus.cs_n, 5'b11111);
        rst = 1'b0;

        // Mode 0, div=0, len=8, loopback
        setup(0, 0, 8'd0, 5'd8, 3'd0, 16'h00A5);
        fire('{rx:16'h00A5, lat:18, cs:5'b11110, tog:16, gap:-1}, 1'b1);
        chk("busy_cycle1", bus.busy, 1);
        chk("mosi_first_bit", bus.mosi, 1);
        wait_done(1);
        repeat (3) @(negedge clk);
        chk("mosi_holds_last", bus.mosi, 1);

        // Mode 3, div=2, len=12, follower returns 0x0123
        fol_sh = 16'h1230;
        fol_en = 1'b1;
        setup(1, 1, 8'd2, 5'd12, 3'd2, 16'h0ABC);
        fire('{rx:16'h0123, lat:76, cs:5'b11011, tog:24, gap:-1}, 1'b1);
        wait_done(2);
        fol_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("sclk_rest_high", bus.sclk, 1);

        // len=0 means full width; mode 1, div=1, loopback
        setup(0, 1, 8'd1, 5'd0, 3'd1, 16'hBEEF);
        fire('{rx:16'hBEEF, lat:67, cs:5'b11101, tog:32, gap:-1}, 1'b1);
        wait_done(3);

        // Out-of-range select plus a second start (with new inputs) at cycle 5
        setup(0, 0, 8'd0, 5'd8, 3'd7, 16'h003C);
        fire('{rx:16'h003C, lat:18, cs:5'b11111, tog:16, gap:-1}, 1'b1);
        repeat (4) @(negedge clk);
        bus.start   = 1'b1;
        bus.tx_data = 16'hFFFF;
        bus.cs_sel  = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(4);
        repeat (40) @(negedge clk);

        // Reset at cycle 9 of a mode-2 transfer: no done, outputs back to reset values
        setup(1, 0, 8'd0, 5'd8, 3'd1, 16'h0066);
        fire('{rx:16'h0, lat:0, cs:5'b0, tog:0, gap:-1}, 1'b0);
        repeat (8) @(negedge clk);
        chk("busy_before_rst", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs_n", bus.cs_n, 5'b11111);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_sclk", bus.sclk, 0);
        chk("midrst_rx_data", bus.rx_data, 0);
        chk("midrst_done", bus.done, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        setup(0, 0, 8'd0, 5'd8, 3'd3, 16'h005A);
        fire('{rx:16'h005A, lat:18, cs:5'b10111, tog:16, gap:-1}, 1'b1);
        wait_done(5);

        // start held high: three back-to-back 4-bit transfers
        setup(0, 0, 8'd0, 5'd4, 3'd0, 16'h0009);
        base = done_seen;
        exp_q.push_back('{rx:16'h0009, lat:10, cs:5'b11110, tog:8, gap:-1});
        exp_q.push_back('{rx:16'h0009, lat:10, cs:5'b11110, tog:8, gap:1});
        exp_q.push_back('{rx:16'h0009, lat:10, cs:5'b11110, tog:8, gap:1});
        bus.start = 1'b1;
        wait_done(base + 2);
        bus.start = 1'b0;
        wait_done(base + 3);
        repeat (20) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
